mem_writer: RTL

//   Streaming write controller for the synchronous memories (ROM/RAM family, DATA_WIDTH x DEPTH).

---
 rtl/mem_writer.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/mem_writer.sv
// Streaming burst writer: accepts words over valid/ready and writes them to consecutive, wrapping addresses.
// Optional read-back XOR checksum verification is compiled in with MEM_WRITER_VERIFY_EN.
module mem_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done
`ifdef MEM_WRITER_VERIFY_EN
    ,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  verify_err
`endif
);

    localparam int                  LEN_W     = ADDR_WIDTH + 1;
    localparam logic [LEN_W-1:0]    DEPTH_LEN = LEN_W'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, WRITE, VERIFY, VCHECK, DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [LEN_W-1:0]        len_q, len_d;
    logic [LEN_W-1:0]        cnt_q, cnt_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    accept;
    logic                    last_beat;

`ifdef MEM_WRITER_VERIFY_EN
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic [LEN_W-1:0]        rcnt_q, rcnt_d;
    logic                    rd_vld_q, rd_vld_d;
    logic                    acc_vld_q, acc_vld_d;
    logic [DATA_WIDTH-1:0]   wsum_q, wsum_d;
    logic [DATA_WIDTH-1:0]   rsum_q, rsum_d;
    logic                    verify_err_q, verify_err_d;
`endif

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_WIDTH'(1);
    endfunction

    assign s_ready   = (state_q == WRITE);
    assign accept    = s_valid && s_ready;
    assign last_beat = (cnt_q == len_q - LEN_W'(1));

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
`ifdef MEM_WRITER_VERIFY_EN
        rd_ptr_d     = rd_ptr_q;
        rd_addr_d    = rd_addr_q;
        rcnt_d       = rcnt_q;
        rd_vld_d     = 1'b0;
        acc_vld_d    = rd_vld_q;
        wsum_d       = wsum_q;
        rsum_d       = acc_vld_q ? (rsum_q ^ rd_data) : rsum_q;
        verify_err_d = verify_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d   = base_addr;
                    len_d   = (length > DEPTH_LEN) ? DEPTH_LEN : length;
                    cnt_d   = '0;
                    state_d = (length == '0) ? DONE : WRITE;
`ifdef MEM_WRITER_VERIFY_EN
                    rd_ptr_d     = base_addr;
                    rcnt_d       = '0;
                    wsum_d       = '0;
                    rsum_d       = '0;
                    verify_err_d = 1'b0;
`endif
                end
            end
            WRITE: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = s_data;
                    ptr_d     = next_addr(ptr_q);
                    cnt_d     = cnt_q + LEN_W'(1);
`ifdef MEM_WRITER_VERIFY_EN
                    wsum_d    = wsum_q ^ s_data;
                    if (last_beat) state_d = VERIFY;
`else
                    if (last_beat) state_d = DONE;
`endif
                end
            end
`ifdef MEM_WRITER_VERIFY_EN
            // The first read registers during the last write cycle, so it reaches memory after the write lands.
            VERIFY: begin
                if (rcnt_q != len_q) begin
                    rd_addr_d = rd_ptr_q;
                    rd_vld_d  = 1'b1;
                    rd_ptr_d  = next_addr(rd_ptr_q);
                    rcnt_d    = rcnt_q + LEN_W'(1);
                end else if (!rd_vld_q && acc_vld_q) begin
                    state_d = VCHECK;
                end
            end
            VCHECK: begin
                verify_err_d = (rsum_q != wsum_q);
                state_d      = DONE;
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef MEM_WRITER_VERIFY_EN
            rd_ptr_q     <= '0;
            rd_addr_q    <= '0;
            rcnt_q       <= '0;
            rd_vld_q     <= 1'b0;
            acc_vld_q    <= 1'b0;
            wsum_q       <= '0;
            rsum_q       <= '0;
            verify_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef MEM_WRITER_VERIFY_EN
            rd_ptr_q     <= rd_ptr_d;
            rd_addr_q    <= rd_addr_d;
            rcnt_q       <= rcnt_d;
            rd_vld_q     <= rd_vld_d;
            acc_vld_q    <= acc_vld_d;
            wsum_q       <= wsum_d;
            rsum_q       <= rsum_d;
            verify_err_q <= verify_err_d;
`endif
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;
    assign done    = done_q;
`ifdef MEM_WRITER_VERIFY_EN
    assign rd_addr    = rd_addr_q;
    assign verify_err = verify_err_q;
`endif

endmodule
